// File: rtl/sv_inside_set_engine.sv
// Sequential evaluator for SystemVerilog 'inside': a loaded table of values and ranges is
// scanned one entry per cycle against a query, reporting match and first-hit index.
module sv_inside_set_engine #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int WW    = $clog2(W + 1),
    localparam int IW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_range,
    input  logic [W-1:0]  ld_lo,
    input  logic [WW-1:0] ld_lo_w,
    input  logic          ld_lo_s,
    input  logic [W-1:0]  ld_hi,
    input  logic [WW-1:0] ld_hi_w,
    input  logic          ld_hi_s,
    input  logic          ld_last,
    input  logic          q_valid,
    output logic          q_ready,
    input  logic [W-1:0]  q_val,
    input  logic [WW-1:0] q_w,
    input  logic          q_s,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_match,
    output logic [IW-1:0] res_idx,
    output logic          ovf
);

    typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_LOADED, S_SCAN, S_RESP} state_t;

    state_t state, state_n;

    logic [CW-1:0] count;
    logic [IW-1:0] i;
    logic          hit;
    logic [IW-1:0] idx;

    logic          tbl_range [DEPTH];
    logic [W-1:0]  tbl_lo    [DEPTH];
    logic [WW-1:0] tbl_lo_w  [DEPTH];
    logic          tbl_lo_s  [DEPTH];
    logic [W-1:0]  tbl_hi    [DEPTH];
    logic [WW-1:0] tbl_hi_w  [DEPTH];
    logic          tbl_hi_s  [DEPTH];

    logic [W-1:0]  qv;
    logic [WW-1:0] qw;
    logic          qs;

    logic ld_fire, q_fire, ovf_set, last_entry, cur_match;

    function automatic int eff_w(input logic [WW-1:0] w);
        if (w == '0)
            return 1;
        else if (int'(w) > W)
            return W;
        else
            return int'(w);
    endfunction

    // Extending straight to W+1 bits gives the same ordering as extending to the
    // pairwise context width, so every compare can share one signed comparator width.
    function automatic logic signed [W:0] ext(input logic [W-1:0] v, input logic [WW-1:0] w,
                                             input logic sgn);
        int              ew;
        logic            msb;
        logic signed [W:0] r;
        ew  = eff_w(w);
        msb = 1'b0;
        r   = '0;
        for (int k = 0; k < W; k++)
            if (k == ew - 1) msb = v[k];
        for (int k = 0; k < W; k++)
            r[k] = (k < ew) ? v[k] : (sgn & msb);
        r[W] = sgn & msb;
        return r;
    endfunction

    function automatic logic cmp_le(input logic [W-1:0] a, input logic [WW-1:0] wa, input logic sa,
                                    input logic [W-1:0] b, input logic [WW-1:0] wb, input logic sb);
        logic ctx_s;
        ctx_s = sa & sb;
        return ext(a, wa, ctx_s) <= ext(b, wb, ctx_s);
    endfunction

    function automatic logic cmp_eq(input logic [W-1:0] a, input logic [WW-1:0] wa, input logic sa,
                                    input logic [W-1:0] b, input logic [WW-1:0] wb, input logic sb);
        logic ctx_s;
        ctx_s = sa & sb;
        return ext(a, wa, ctx_s) == ext(b, wb, ctx_s);
    endfunction

    always_comb begin
        cur_match = 1'b0;
        if (tbl_range[i])
            cur_match = cmp_le(tbl_lo[i], tbl_lo_w[i], tbl_lo_s[i], qv, qw, qs) &
                        cmp_le(qv, qw, qs, tbl_hi[i], tbl_hi_w[i], tbl_hi_s[i]);
        else
            cur_match = cmp_eq(qv, qw, qs, tbl_lo[i], tbl_lo_w[i], tbl_lo_s[i]);
    end

    assign last_entry = (CW'(i) == count - CW'(1));
    assign ld_fire    = ld_valid & ld_ready & ~clr;
    assign q_fire     = q_valid & q_ready & ~clr;
    assign ovf_set    = (state == S_LOAD) & ld_valid & ~ld_ready & ~clr;
    assign res_match  = hit;
    assign res_idx    = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_EMPTY;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ld_ready  = 1'b0;
        q_ready   = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_EMPTY: begin
                ld_ready = 1'b1;
                if (ld_valid) state_n = ld_last ? S_LOADED : S_LOAD;
            end
            S_LOAD: begin
                ld_ready = (count < CW'(DEPTH));
                // A member offered to a full table is dropped and closes the set.
                if (ld_valid && (ld_last || !ld_ready)) state_n = S_LOADED;
            end
            S_LOADED: begin
                q_ready = 1'b1;
                if (q_valid) state_n = S_SCAN;
            end
            S_SCAN: begin
                if (last_entry) state_n = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_n = S_LOADED;
            end
            default: state_n = S_EMPTY;
        endcase
        if (clr) state_n = S_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            i     <= '0;
            hit   <= 1'b0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            i     <= '0;
            hit   <= 1'b0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (ld_fire) count <= count + CW'(1);
            if (ovf_set) ovf <= 1'b1;
            if (q_fire) begin
                i   <= '0;
                hit <= 1'b0;
                idx <= '0;
            end else if (state == S_SCAN) begin
                // Keep stepping after the first hit so latency depends only on count.
                if (cur_match && !hit) begin
                    hit <= 1'b1;
                    idx <= i;
                end
                i <= i + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            tbl_range[count[IW-1:0]] <= ld_range;
            tbl_lo[count[IW-1:0]]    <= ld_lo;
            tbl_lo_w[count[IW-1:0]]  <= ld_lo_w;
            tbl_lo_s[count[IW-1:0]]  <= ld_lo_s;
            tbl_hi[count[IW-1:0]]    <= ld_hi;
            tbl_hi_w[count[IW-1:0]]  <= ld_hi_w;
            tbl_hi_s[count[IW-1:0]]  <= ld_hi_s;
        end
        if (q_fire) begin
            qv <= q_val;
            qw <= q_w;
            qs <= q_s;
        end
    end

endmodule

// File: tb/tb_sv_inside_set_engine.sv
// Scoreboard bench for sv_inside_set_engine: integer-arithmetic model of 'inside' rules,
// directed cases plus randomized sets and queries.
module tb_sv_inside_set_engine;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int WW    = $clog2(W + 1);
    localparam int IW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n, clr;
    logic ld_valid, ld_ready, ld_range, ld_lo_s, ld_hi_s, ld_last;
    logic [W-1:0] ld_lo, ld_hi, q_val;
    logic [WW-1:0] ld_lo_w, ld_hi_w, q_w;
    logic q_valid, q_ready, q_s, res_valid, res_ready, res_match, ovf;
    logic [IW-1:0] res_idx;

    sv_inside_set_engine #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_range(ld_range),
        .ld_lo(ld_lo), .ld_lo_w(ld_lo_w), .ld_lo_s(ld_lo_s),
        .ld_hi(ld_hi), .ld_hi_w(ld_hi_w), .ld_hi_s(ld_hi_s), .ld_last(ld_last),
        .q_valid(q_valid), .q_ready(q_ready), .q_val(q_val), .q_w(q_w), .q_s(q_s),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_idx(res_idx), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model of the loaded set
    int           m_cnt = 0;
    bit           m_rng [DEPTH];
    logic [W-1:0] m_lo  [DEPTH];
    logic [W-1:0] m_hi  [DEPTH];
    int           m_lw  [DEPTH];
    int           m_hw  [DEPTH];
    bit           m_ls  [DEPTH];
    bit           m_hs  [DEPTH];

    typedef struct {
        bit m;
        int idx;
        int lat;
        int acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int waited);
        checks++;
        failures++;
        $display("FAIL %s timeout waited=%0d cycles required=handshake", name, waited);
    endtask

    // Integer value of an operand inside a comparison context of the given signedness.
    function automatic longint opval(input logic [W-1:0] bits, input int w, input bit sctx);
        int ew;
        longint x;
        ew = (w == 0) ? 1 : ((w > W) ? W : w);
        x = longint'(bits) & ((longint'(1) << ew) - 1);
        if (sctx && ((x >> (ew - 1)) & 1) == 1) x = x - (longint'(1) << ew);
        return x;
    endfunction

    function automatic bit model_hit(input int k, input logic [W-1:0] q, input int qw, input bit qs);
        if (m_rng[k])
            return (opval(m_lo[k], m_lw[k], m_ls[k] & qs) <= opval(q, qw, m_ls[k] & qs)) &&
                   (opval(q, qw, qs & m_hs[k]) <= opval(m_hi[k], m_hw[k], qs & m_hs[k]));
        else
            return opval(q, qw, qs & m_ls[k]) == opval(m_lo[k], m_lw[k], qs & m_ls[k]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_member(input bit rng, input logic [W-1:0] lo, input int lw, input bit ls,
                              input logic [W-1:0] hi, input int hw, input bit hs, input bit last);
        int n;
        ld_valid = 1'b1; ld_range = rng; ld_last = last;
        ld_lo = lo; ld_lo_w = WW'(lw); ld_lo_s = ls;
        ld_hi = hi; ld_hi_w = WW'(hw); ld_hi_s = hs;
        n = 0;
        forever begin
            @(negedge clk);
            if (ld_ready || n > 100) break;
            n++;
        end
        if (!ld_ready) begin
            timeout_fail("ld_accept", n);
        end else begin
            m_rng[m_cnt] = rng; m_lo[m_cnt] = lo; m_lw[m_cnt] = lw; m_ls[m_cnt] = ls;
            m_hi[m_cnt] = hi; m_hw[m_cnt] = hw; m_hs[m_cnt] = hs;
            m_cnt++;
        end
        tick();
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic query(input logic [W-1:0] v, input int w, input bit s, input bit push,
                         input bit use_c, input bit cm, input int ci);
        int n;
        exp_t e;
        q_valid = 1'b1; q_val = v; q_w = WW'(w); q_s = s;
        n = 0;
        forever begin
            @(negedge clk);
            if (q_ready || n > 300) break;
            n++;
        end
        if (!q_ready) begin
            timeout_fail("q_accept", n);
        end else if (push) begin
            e.m = 1'b0; e.idx = 0;
            for (int k = 0; k < m_cnt; k++)
                if (!e.m && model_hit(k, v, w, s)) begin
                    e.m = 1'b1;
                    e.idx = k;
                end
            if (use_c) begin
                e.m = cm;
                e.idx = ci;
            end
            e.lat = m_cnt + 1;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        tick();
        q_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((exp_q.size() == 0 && !res_valid) || n > 400) break;
            n++;
        end
        if (exp_q.size() != 0 || res_valid) timeout_fail("drain", n);
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_cnt = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ld_ready"}, ld_ready, 1);
        chk({tag, "_q_ready"}, q_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_match"}, res_match, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    bit seen = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result res_valid=1 required=0 (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_match", res_match, e.m);
                        chk("res_idx", res_idx, e.idx);
                        chk("latency", cyc - e.acc, e.lat);
                    end
                end
                if (res_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hcount;
        bit rng;
        logic [W-1:0] v;
        rst_n = 1'b0; clr = 1'b0;
        ld_valid = 0; ld_range = 0; ld_lo = '0; ld_lo_w = '0; ld_lo_s = 0;
        ld_hi = '0; ld_hi_w = '0; ld_hi_s = 0; ld_last = 0;
        q_valid = 0; q_val = '0; q_w = '0; q_s = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // {4'sb1100} inside query 3'sb100
        add_member(0, 8'hC, 4, 1, 8'h0, 0, 0, 1);
        query(8'h4, 3, 1, 1, 1, 1, 0);
        drain(); do_clr();
        // {4'b1100} vs 3'sb100
        add_member(0, 8'hC, 4, 0, 8'h0, 0, 0, 1);
        query(8'h4, 3, 1, 1, 1, 0, 0);
        drain(); do_clr();
        // {3'sb100} vs 4'sb1100 and 4'b1100
        add_member(0, 8'h4, 3, 1, 8'h0, 0, 0, 1);
        query(8'hC, 4, 1, 1, 1, 1, 0);
        query(8'hC, 4, 0, 1, 1, 0, 0);
        drain(); do_clr();
        // {[4'b0:3'sb100]} vs 1'sb1
        add_member(1, 8'h0, 4, 0, 8'h4, 3, 1, 1);
        query(8'h1, 1, 1, 1, 1, 0, 0);
        drain(); do_clr();
        // {[1'sb1:1'sb1]} vs 1'sb1
        add_member(1, 8'h1, 1, 1, 8'h1, 1, 1, 1);
        query(8'h1, 1, 1, 1, 1, 1, 0);
        drain(); do_clr();
        // {4'sb0, [3'sb100:4'sb0], 4'sb1100} vs 4'sb1100; query refused during LOAD
        add_member(0, 8'h0, 4, 1, 8'h0, 0, 0, 0);
        q_valid = 1'b1;
        @(negedge clk);
        chk("q_ready_in_load", q_ready, 0);
        q_valid = 1'b0;
        tick();
        add_member(1, 8'h4, 3, 1, 8'h0, 4, 1, 0);
        add_member(0, 8'hC, 4, 1, 8'h0, 0, 0, 1);
        query(8'hC, 4, 1, 1, 1, 1, 1);
        drain(); do_clr();
        @(negedge clk);
        chk("q_ready_in_empty", q_ready, 0);
        tick();

        // Overflow: DEPTH+1 members without ld_last
        for (int k = 0; k < DEPTH; k++) add_member(0, W'(k + 1), 8, 0, 8'h0, 0, 0, 0);
        @(negedge clk);
        chk("full_ld_ready", ld_ready, 0);
        chk("full_ovf_before", ovf, 0);
        ld_valid = 1'b1; ld_lo = 8'h55;
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_q_ready", q_ready, 1);
        chk("ovf_ld_ready", ld_ready, 0);
        tick();
        query(W'(DEPTH), 8, 0, 1, 1, 1, DEPTH - 1);
        query(8'h55, 8, 0, 1, 1, 0, 0);
        drain();

        // clr during SCAN discards the pending result
        query(8'h3, 8, 0, 0, 0, 0, 0);
        tick(); tick();
        do_clr();
        @(negedge clk);
        chk("clr_ld_ready", ld_ready, 1);
        chk("clr_res_valid", res_valid, 0);
        chk("clr_ovf", ovf, 0);
        hcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) hcount++;
        end
        chk("clr_no_result", hcount, 0);
        tick();

        // Async reset during LOAD
        for (int k = 0; k < 3; k++) add_member(0, W'(k), 8, 0, 8'h0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_load");
        m_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Async reset during SCAN after the first entry already hit
        add_member(0, 8'h5, 8, 0, 8'h0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add_member(0, 8'h5, 8, 0, 8'h0, 0, 0, k == 4);
        query(8'h5, 8, 0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_scan");
        m_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized sets and queries
        for (int s = 0; s < 30; s++) begin
            drain();
            do_clr();
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                rng = ($urandom_range(0, 2) == 0);
                add_member(rng, W'($urandom), $urandom_range(0, W), 1'($urandom),
                           W'($urandom), $urandom_range(0, W), 1'($urandom), k == n - 1);
            end
            for (int qn = 0; qn < 6; qn++) begin
                case ($urandom_range(0, 2))
                    0: v = m_lo[$urandom_range(0, m_cnt - 1)];
                    1: v = m_hi[$urandom_range(0, m_cnt - 1)];
                    default: v = W'($urandom);
                endcase
                query(v, $urandom_range(0, W), 1'($urandom), 1, 0, 0, 0);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
